// File: rtl/dut_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dut_tester_pkg
// Purpose  : Shared widths, run-state encoding and a saturating counter helper
//            for the tester drive/receive blocks.
// Revision : 1.0 - initial release
// ============================================================================
package dut_tester_pkg;

    localparam int WIDTH  = 128;
    localparam int CLEN_W = 8;
    localparam int STB_W  = 7;
    localparam int CNT_W  = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dut_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : dut_cycle_timer
// Purpose  : Tester-cycle position counter producing the end-of-cycle wrap and
//            the strobe hit. Shared by the drive and receive sides.
// Revision : 1.0 - initial release
// ============================================================================
module dut_cycle_timer #(
    parameter int CLEN_W = 8,
    parameter int STB_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CLEN_W-1:0] length,
    input  logic [STB_W-1:0]  strobe,
    output logic [CLEN_W-1:0] cnt,
    output logic              wrap,
    output logic              hit
);

    localparam int EXT_W = (CLEN_W > STB_W) ? CLEN_W : STB_W;

    logic [CLEN_W-1:0] r_cnt;
    logic [CLEN_W-1:0] w_last;
    logic [EXT_W-1:0]  w_cnt_ext;
    logic [EXT_W-1:0]  w_stb_ext;
    logic [EXT_W-1:0]  w_last_ext;

    // Last position of the cycle; a zero length behaves as a one-clock cycle.
    // Wrapping on >= keeps the counter from running away if the length is
    // lowered while running.
    always_comb begin
        w_last     = (length == '0) ? '0 : length - CLEN_W'(1);
        w_cnt_ext  = EXT_W'(r_cnt);
        w_stb_ext  = EXT_W'(strobe);
        w_last_ext = EXT_W'(w_last);
        wrap       = run && (r_cnt >= w_last);
        hit        = run && (w_cnt_ext == w_stb_ext) && (w_stb_ext <= w_last_ext);
    end

    // Position counter: held at 0 when not running, restarts after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run || wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CLEN_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dut_resp_cmp.sv
`default_nettype none
// ============================================================================
// Module   : dut_resp_cmp
// Purpose  : Samples DUT response pins once per tester cycle at the strobe,
//            compares against a double-buffered expected/mask pattern and
//            accumulates sticky fail flags plus fail/cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module dut_resp_cmp
    import dut_tester_pkg::*;
#(
    parameter int WIDTH  = dut_tester_pkg::WIDTH,
    parameter int CLEN_W = dut_tester_pkg::CLEN_W,
    parameter int STB_W  = dut_tester_pkg::STB_W,
    parameter int CNT_W  = dut_tester_pkg::CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PERFORM_TEST,
    input  logic [WIDTH-1:0]  BUS128_0,
    input  logic [WIDTH-1:0]  BUS128_1,
    input  logic              EXP_LOAD,
    input  logic              EXP_TRANSFER,
    input  logic [STB_W-1:0]  STROBE_1,
    input  logic [CLEN_W-1:0] CYCLE_LENGTH_1,
    input  logic              CLEAR_FAILS,
    input  logic [WIDTH-1:0]  INPUT_SIGNALS,
    output logic [WIDTH-1:0]  FAIL_FLAGS,
    output logic              FAIL_ANY,
    output logic [CNT_W-1:0]  FAIL_COUNT,
    output logic [CNT_W-1:0]  CYCLE_COUNT,
    output logic              RUNNING
);

    run_state_t        r_state;
    run_state_t        w_state_nxt;

    logic [WIDTH-1:0]  r_in_q;
    logic [WIDTH-1:0]  r_shadow_exp;
    logic [WIDTH-1:0]  r_shadow_mask;
    logic [WIDTH-1:0]  r_act_exp;
    logic [WIDTH-1:0]  r_act_mask;
    logic              r_pending;
    logic [WIDTH-1:0]  r_fail_flags;
    logic              r_fail_any;
    logic [CNT_W-1:0]  r_fail_count;
    logic [CNT_W-1:0]  r_cycle_count;

    logic              w_run;
    logic              w_wrap;
    logic              w_hit;
    logic [CLEN_W-1:0] w_cnt_unused;
    logic [WIDTH-1:0]  w_mm;
    logic              w_copy;
    logic              w_pending_nxt;
    logic [WIDTH-1:0]  w_flags_nxt;
    logic [CNT_W-1:0]  w_fail_base;
    logic [CNT_W-1:0]  w_fail_count_nxt;
    logic [CNT_W-1:0]  w_cycle_base;
    logic [CNT_W-1:0]  w_cycle_count_nxt;

    // Run state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run state transitions follow the PERFORM_TEST level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (PERFORM_TEST)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!PERFORM_TEST) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The clock that drops PERFORM_TEST already behaves as idle, so the
    // partial cycle neither strobes nor wraps.
    assign w_run = (r_state == ST_RUN) && PERFORM_TEST;

    dut_cycle_timer #(
        .CLEN_W (CLEN_W),
        .STB_W  (STB_W)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .run    (w_run),
        .length (CYCLE_LENGTH_1),
        .strobe (STROBE_1),
        .cnt    (w_cnt_unused),
        .wrap   (w_wrap),
        .hit    (w_hit)
    );

    // Compare, pattern hand-over and next counter values.
    always_comb begin
        w_mm = w_hit ? ((r_in_q ^ r_act_exp) & r_act_mask) : '0;

        // While running, a transfer waits for the cycle boundary so one cycle
        // never mixes old and new patterns; otherwise it (or a leftover
        // pending request) takes effect immediately.
        w_copy        = w_run ? (w_wrap && (r_pending || EXP_TRANSFER))
                              : (r_pending || EXP_TRANSFER);
        w_pending_nxt = w_run && !w_wrap && (r_pending || EXP_TRANSFER);

        // Clear first, then fold in this clock's result.
        w_flags_nxt       = (CLEAR_FAILS ? '0 : r_fail_flags) | w_mm;
        w_fail_base       = CLEAR_FAILS ? '0 : r_fail_count;
        w_fail_count_nxt  = (|w_mm) ? sat_inc(w_fail_base) : w_fail_base;
        w_cycle_base      = CLEAR_FAILS ? '0 : r_cycle_count;
        w_cycle_count_nxt = w_wrap ? sat_inc(w_cycle_base) : w_cycle_base;
    end

    // Pin sample and expected/mask double buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_q        <= '0;
            r_shadow_exp  <= '0;
            r_shadow_mask <= '0;
            r_act_exp     <= '0;
            r_act_mask    <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_in_q    <= INPUT_SIGNALS;
            r_pending <= w_pending_nxt;
            if (EXP_LOAD) begin
                r_shadow_exp  <= BUS128_0;
                r_shadow_mask <= BUS128_1;
            end
            if (w_copy) begin
                r_act_exp  <= r_shadow_exp;
                r_act_mask <= r_shadow_mask;
            end
        end
    end

    // Fail flags and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fail_flags  <= '0;
            r_fail_any    <= 1'b0;
            r_fail_count  <= '0;
            r_cycle_count <= '0;
        end else begin
            r_fail_flags  <= w_flags_nxt;
            r_fail_any    <= |r_fail_flags;
            r_fail_count  <= w_fail_count_nxt;
            r_cycle_count <= w_cycle_count_nxt;
        end
    end

    assign FAIL_FLAGS  = r_fail_flags;
    assign FAIL_ANY    = r_fail_any;
    assign FAIL_COUNT  = r_fail_count;
    assign CYCLE_COUNT = r_cycle_count;
    assign RUNNING     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dut_resp_cmp.sv
`default_nettype none
// ============================================================================
// Module   : tb_dut_resp_cmp
// Purpose  : Self-checking bench for dut_resp_cmp: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dut_resp_cmp;

    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          perform_test;
    logic [W-1:0]  bus0;
    logic [W-1:0]  bus1;
    logic          exp_load;
    logic          exp_transfer;
    logic [6:0]    strobe;
    logic [7:0]    cycle_length;
    logic          clear_fails;
    logic [W-1:0]  input_signals;
    logic [W-1:0]  fail_flags;
    logic          fail_any;
    logic [15:0]   fail_count;
    logic [15:0]   cycle_count;
    logic          running;

    dut_resp_cmp dut (
        .CLK            (clk),
        .RST            (rst),
        .PERFORM_TEST   (perform_test),
        .BUS128_0       (bus0),
        .BUS128_1       (bus1),
        .EXP_LOAD       (exp_load),
        .EXP_TRANSFER   (exp_transfer),
        .STROBE_1       (strobe),
        .CYCLE_LENGTH_1 (cycle_length),
        .CLEAR_FAILS    (clear_fails),
        .INPUT_SIGNALS  (input_signals),
        .FAIL_FLAGS     (fail_flags),
        .FAIL_ANY       (fail_any),
        .FAIL_COUNT     (fail_count),
        .CYCLE_COUNT    (cycle_count),
        .RUNNING        (running)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [W-1:0] m_shadow_exp, m_shadow_mask, m_act_exp, m_act_mask, m_inq, m_flags;
    bit           m_run, m_pend, m_fany;
    int           m_pos, m_fcnt, m_ccnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;

    localparam logic [W-1:0] ONES = {W{1'b1}};
    localparam logic [W-1:0] AAAA = {4{32'hAAAA_AAAA}};

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock of tester behaviour, stated in tester-cycle terms.
    function automatic void model_step();
        int           len_eff;
        bit           active, strobe_now, wrap_now, do_copy;
        logic [W-1:0] mm;
        if (rst) begin
            m_shadow_exp = '0; m_shadow_mask = '0; m_act_exp = '0; m_act_mask = '0;
            m_inq = '0; m_flags = '0; m_run = 0; m_pend = 0; m_fany = 0;
            m_pos = 0; m_fcnt = 0; m_ccnt = 0;
            return;
        end
        len_eff    = (cycle_length == 0) ? 1 : int'(cycle_length);
        active     = m_run && perform_test;
        strobe_now = active && (m_pos == int'(strobe));
        wrap_now   = active && (m_pos == len_eff - 1);
        mm         = strobe_now ? ((m_inq ^ m_act_exp) & m_act_mask) : '0;
        m_fany     = |m_flags;
        if (clear_fails) begin
            m_flags = '0; m_fcnt = 0; m_ccnt = 0;
        end
        m_flags = m_flags | mm;
        if (mm != '0 && m_fcnt < 65535) m_fcnt++;
        if (wrap_now && m_ccnt < 65535) m_ccnt++;
        do_copy = active ? (wrap_now && (m_pend || exp_transfer)) : (m_pend || exp_transfer);
        if (do_copy) begin
            m_act_exp = m_shadow_exp; m_act_mask = m_shadow_mask; m_pend = 0;
        end else if (exp_transfer) begin
            m_pend = 1;
        end
        if (exp_load) begin
            m_shadow_exp = bus0; m_shadow_mask = bus1;
        end
        m_pos = (active && !wrap_now) ? (m_pos + 1) % len_eff : 0;
        m_run = perform_test;
        m_inq = input_signals;
    endfunction

    task automatic check_all();
        check("fail_flags",  fail_flags, m_flags);
        check("fail_any",    W'(fail_any), W'(m_fany));
        check("fail_count",  W'(fail_count), W'(m_fcnt));
        check("cycle_count", W'(cycle_count), W'(m_ccnt));
        check("running",     W'(running), W'(m_run));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (chk_en) check_all();
        end
    endtask

    task automatic load_pattern(input logic [W-1:0] e, input logic [W-1:0] m);
        bus0 = e; bus1 = m; exp_load = 1'b1;
        step(1);
        exp_load = 1'b0; exp_transfer = 1'b1;
        step(1);
        exp_transfer = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_fails = 1'b1;
        step(1);
        clear_fails = 1'b0;
    endtask

    initial begin
        rst = 1'b1; perform_test = 1'b0; bus0 = '0; bus1 = '0;
        exp_load = 1'b0; exp_transfer = 1'b0; strobe = 7'd20; cycle_length = 8'd80;
        clear_fails = 1'b0; input_signals = '0;

        // Reset and idle
        step(10);
        rst = 1'b0;
        step(5);
        check("rst_flags", fail_flags, '0);
        check("rst_count", W'(fail_count), '0);
        check("rst_cycles", W'(cycle_count), '0);
        check("rst_running", W'(running), '0);

        // Pass run: 10 full cycles, all matching
        load_pattern(ONES, ONES);
        input_signals = ONES;
        pulse_clear();
        perform_test = 1'b1;
        step(1);
        check("run_rise", W'(running), W'(1));
        step(800);
        perform_test = 1'b0;
        step(1);
        check("pass_cycles", W'(cycle_count), W'(10));
        check("pass_count", W'(fail_count), '0);
        check("pass_flags", fail_flags, '0);

        // Masked fail: 3 cycles
        load_pattern('0, AAAA);
        pulse_clear();
        perform_test = 1'b1;
        step(241);
        perform_test = 1'b0;
        step(2);
        check("mask_flags", fail_flags, AAAA);
        check("mask_count", W'(fail_count), W'(3));
        check("mask_any", W'(fail_any), W'(1));

        // Deferred transfer issued at position 5 of a failing cycle
        pulse_clear();
        perform_test = 1'b1;
        step(4);
        bus0 = ONES; bus1 = ONES; exp_load = 1'b1;
        step(1);
        exp_load = 1'b0;
        step(1);
        exp_transfer = 1'b1;
        step(1);
        exp_transfer = 1'b0;
        step(400);
        perform_test = 1'b0;
        step(1);
        check("defer_count", W'(fail_count), W'(1));

        // Strobe beyond cycle length
        load_pattern('0, AAAA);
        pulse_clear();
        strobe = 7'd90;
        perform_test = 1'b1;
        step(161);
        perform_test = 1'b0;
        step(1);
        check("nostb_count", W'(fail_count), '0);
        check("nostb_cycles", W'(cycle_count), W'(2));

        // Zero cycle length: a wrap every clock
        pulse_clear();
        cycle_length = 8'd0; strobe = 7'd5;
        perform_test = 1'b1;
        step(8);
        check("len0_cycles", W'(cycle_count), W'(7));
        perform_test = 1'b0;
        step(1);

        // Saturation of both counters
        pulse_clear();
        cycle_length = 8'd1; strobe = 7'd0;
        perform_test = 1'b1;
        step(1);
        chk_en = 1'b0;
        step(65540);
        chk_en = 1'b1;
        step(1);
        check("sat_fail", W'(fail_count), W'(16'hFFFF));
        check("sat_cycles", W'(cycle_count), W'(16'hFFFF));
        perform_test = 1'b0;
        step(1);

        // Clear coincident with a failing strobe, then abort mid-cycle
        cycle_length = 8'd80; strobe = 7'd20;
        pulse_clear();
        perform_test = 1'b1;
        step(181);
        check("pre_clear_count", W'(fail_count), W'(2));
        clear_fails = 1'b1;
        step(1);
        clear_fails = 1'b0;
        check("clr_strobe_count", W'(fail_count), W'(1));
        check("clr_strobe_cycles", W'(cycle_count), '0);
        step(19);
        perform_test = 1'b0;
        step(1);
        check("abort_running", W'(running), '0);
        check("abort_cycles", W'(cycle_count), '0);

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            logic [W-1:0] e;
            int           dur;
            cycle_length = 8'($urandom_range(0, 40));
            strobe       = 7'($urandom_range(0, 45));
            e = rand128();
            load_pattern(e, rand128());
            perform_test = 1'b1;
            dur = $urandom_range(20, 200);
            for (int k = 0; k < dur; k++) begin
                input_signals = e ^ (rand128() & rand128() & rand128());
                exp_load      = ($urandom_range(0, 19) == 0);
                if (exp_load) begin
                    bus0 = rand128(); bus1 = rand128();
                end
                exp_transfer = ($urandom_range(0, 14) == 0);
                clear_fails  = ($urandom_range(0, 29) == 0);
                step(1);
            end
            exp_load = 1'b0; exp_transfer = 1'b0; clear_fails = 1'b0;
            perform_test = 1'b0;
            step(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
